// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared FSM state encoding, opcode constants and
// instruction field helpers for the fetch stage.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    FS_BOOT  = 2'd0,
    FS_FETCH = 2'd1,
    FS_FULL  = 2'd2
  } fetch_state_e;

  localparam logic [5:0] OP_BEQ = 6'b000100;

  function automatic logic [5:0] op_f(input logic [31:0] i);
    return i[31:26];
  endfunction

  function automatic logic [4:0] rs_f(input logic [31:0] i);
    return i[25:21];
  endfunction

  function automatic logic [4:0] rt_f(input logic [31:0] i);
    return i[20:16];
  endfunction

  function automatic logic [4:0] rd_f(input logic [31:0] i);
    return i[15:11];
  endfunction

  function automatic logic [15:0] imm_f(input logic [31:0] i);
    return i[15:0];
  endfunction

  function automatic logic [5:0] funct_f(input logic [31:0] i);
    return i[5:0];
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry circular FIFO of fetched words. flush empties it
// in one edge and wins over push/pop; count_next is exported so the fetch
// FSM can plan credits on next-cycle occupancy.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int W     = 65
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   count_next
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]           count_q, count_d;

  // Next-state pointer, count and storage update; pointers wrap at DEPTH.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Queue state registers; storage cleared so the head reads 0 in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data  = mem_q[rd_ptr_q];
  assign count      = count_q;
  assign count_next = count_d;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: sequential instruction fetch with a credit-limited queue and
// redirect flush. Define FETCH_STATIC_PREDICT_EN to enable backward-beq
// static prediction on returning words.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int                 ADDR_W   = 32,
  parameter int                 DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic              out_pred_taken
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = ADDR_W + 33;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  localparam logic [1:0] S_BOOT  = FS_BOOT;
  localparam logic [1:0] S_FETCH = FS_FETCH;
  localparam logic [1:0] S_FULL  = FS_FULL;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] fpc_q, fpc_d;    // next fetch address
  logic [ADDR_W-1:0] ipc_q, ipc_d;    // PC of the inflight request
  logic              infl_q, infl_d;
  logic              drop_q, drop_d;

  logic [CW-1:0]     count, count_next;
  logic [CW:0]       occ, occ_next;
  logic [EW-1:0]     head, push_data;
  logic              push, pop, flush;
  logic              pred_fire;
  logic [ADDR_W-1:0] pred_tgt;

  // The response only lands if it was not marked for drop and no redirect
  // is flushing this edge; redirect also blocks the pop.
  assign flush = redirect_valid;
  assign push  = infl_q && !drop_q && !redirect_valid;
  assign pop   = out_valid && out_ready && !redirect_valid;

`ifdef FETCH_STATIC_PREDICT_EN
  logic [15:0]       imm;
  logic [ADDR_W-1:0] boff;
  assign imm       = imm_f(imem_rdata);
  assign boff      = {{(ADDR_W-18){imm[15]}}, imm, 2'b00};
  assign pred_fire = push && (op_f(imem_rdata) == OP_BEQ) && imm[15];
  assign pred_tgt  = ipc_q + ADDR_W'(4) + boff;
  assign out_pred_taken = head[EW-1];
`else
  logic unused_pred;
  assign pred_fire      = 1'b0;
  assign pred_tgt       = fpc_q;
  assign unused_pred    = head[EW-1];
  assign out_pred_taken = 1'b0;
`endif

  assign push_data = {pred_fire, imem_rdata, ipc_q};

  fetch_queue #(.DEPTH(DEPTH), .W(EW)) u_queue (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .push       (push),
    .push_data  (push_data),
    .pop        (pop),
    .head_data  (head),
    .count      (count),
    .count_next (count_next)
  );

  // Credits: queued entries plus the inflight slot (even a dropped one).
  assign occ      = {1'b0, count} + (CW+1)'(infl_q);
  assign occ_next = {1'b0, count_next} + (CW+1)'(infl_d);
  assign imem_req = (state_q == S_FETCH) && (occ < DEPTH_C);
  assign imem_addr = fpc_q;

  assign out_valid = (count != '0);
  assign out_instr = head[ADDR_W+31:ADDR_W];
  assign out_pc    = head[ADDR_W-1:0];

  // Fetch PC, inflight tracking and drop marking for the next edge.
  always_comb begin
    infl_d = imem_req;
    ipc_d  = imem_req ? fpc_q : ipc_q;
    drop_d = imem_req && (redirect_valid || pred_fire);
    fpc_d  = fpc_q;
    if (redirect_valid)  fpc_d = redirect_pc & ~ADDR_W'(3);
    else if (pred_fire)  fpc_d = pred_tgt;
    else if (imem_req)   fpc_d = fpc_q + ADDR_W'(4);
  end

  // FSM: BOOT for one cycle, FETCH until credits run out, FULL until one frees.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_BOOT:  state_d = S_FETCH;
      S_FETCH: if (occ_next >= DEPTH_C) state_d = S_FULL;
      S_FULL:  if (occ_next <  DEPTH_C) state_d = S_FETCH;
      default: state_d = S_BOOT;
    endcase
    if (redirect_valid) state_d = S_FETCH;
  end

  // Control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_BOOT;
      fpc_q   <= RESET_PC;
      ipc_q   <= '0;
      infl_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      ipc_q   <= ipc_d;
      infl_q  <= infl_d;
      drop_q  <= drop_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios with a queue-level reference model
// compared every cycle, plus hand-computed literal checks.
module tb_fetch_stage;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'hDEADBEEF;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_pred_taken;

  int vectors = 0;
  int errs = 0;

  fetch_stage #(.ADDR_W(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_pred_taken (out_pred_taken)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: addr/4, except a backward beq at 0x20.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a == 32'h20) ? 32'h1000FFFE : (a >> 2);
  endfunction

  always @(posedge clk) imem_rdata <= imem_req ? memf(imem_addr) : 32'hDEADBEEF;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [31:0] pc; logic [31:0] instr; logic pred; } ent_t;
  ent_t        mq[$];
  bit          m_boot, m_inf, m_drop;
  logic [31:0] m_fpc, m_ipc;
  bit          s_req, s_pop, s_push, s_pred;
  logic [31:0] s_w, s_old;

  function automatic bit exp_req();
    return !m_boot && ((mq.size() + int'(m_inf)) < DEPTH);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete(); m_boot = 1; m_inf = 0; m_drop = 0; m_fpc = 0; m_ipc = 0;
    end else begin
      s_req  = exp_req();
      s_pop  = (mq.size() > 0) && out_ready;
      s_push = m_inf && !m_drop;
      s_w    = memf(m_ipc);
      s_old  = m_fpc;
      s_pred = 0;
`ifdef FETCH_STATIC_PREDICT_EN
      s_pred = s_push && (s_w[31:26] == 6'd4) && s_w[15];
`endif
      if (redirect_valid) begin
        mq.delete();
        m_fpc = redirect_pc & ~32'd3;
      end else begin
        if (s_pop) mq.delete(0);
        if (s_push) mq.push_back('{m_ipc, s_w, s_pred});
        if (s_pred) m_fpc = m_ipc + 32'd4 + {{14{s_w[15]}}, s_w[15:0], 2'b00};
        else if (s_req) m_fpc = m_fpc + 32'd4;
      end
      m_drop = s_req && (redirect_valid || s_pred);
      m_inf  = s_req;
      if (s_req) m_ipc = s_old;
      m_boot = 0;
    end
  end

  // Per-cycle compare against the model (or reset values while in reset).
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_imem_req", imem_req, 0);
      chk("rst_imem_addr", imem_addr, 32'h0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_pc", out_pc, 32'h0);
      chk("rst_out_instr", out_instr, 32'h0);
      chk("rst_out_pred", out_pred_taken, 0);
    end else begin
      chk("imem_req", imem_req, exp_req());
      if (exp_req()) chk("imem_addr", imem_addr, m_fpc);
      chk("out_valid", out_valid, mq.size() > 0);
      if (mq.size() > 0) begin
        chk("out_pc", out_pc, mq[0].pc);
        chk("out_instr", out_instr, mq[0].instr);
        chk("out_pred", out_pred_taken, mq[0].pred);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic wait_valid(input string nm, input int max);
    int n = 0;
    while (!out_valid && n < max) begin tick(); n++; end
    if (!out_valid) begin
      vectors++; errs++;
      $display("FAIL %s: out_valid not seen within %0d cycles", nm, max);
    end
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1; redirect_pc = pc;
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    int first, nreq, bad;

    // 1: reset release, streaming
    out_ready = 1'b1;
    do_reset();
    first = -1;
    for (int c = 1; c <= 8 && first < 0; c++) begin
      tick();
      if (out_valid) first = c;
    end
    chk("first_valid_cycle", first, 3);
    chk("stream_pc0", out_pc, 32'h0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("stream_valid", out_valid, 1);
      chk("stream_pc", out_pc, 32'(4 * k));
    end

    // 2: mid-run reset, then decode stalled for 10 cycles
    out_ready = 1'b0;
    do_reset();
    nreq = 0; bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (imem_req) nreq++;
      if (out_valid && out_pc != 32'h0) bad++;
      tick();
    end
    chk("stall_req_count", nreq, 4);
    chk("stall_req_off", imem_req, 0);
    chk("stall_pc_changes", bad, 0);
    chk("stall_head_pc", out_pc, 32'h0);

    // 3: redirect with 3 queued + 1 inflight
    do_reset();
    repeat (5) tick();
    chk("pre_redir_valid", out_valid, 1);
    chk("pre_redir_full", imem_req, 0);
    redirect(32'h40);
    chk("redir_empty", out_valid, 0);
    out_ready = 1'b1;
    bad = 0;
    for (int i = 0; i < 10 && !out_valid; i++) tick();
    chk("redir_first_pc", out_pc, 32'h40);
    for (int i = 0; i < 6; i++) begin
      if (out_valid && out_pc >= 32'h0C && out_pc <= 32'h10) bad++;
      tick();
    end
    chk("redir_stale_pcs", bad, 0);

    // 4: redirect coinciding with pop and push (low bits forced to 0)
    chk("steady_valid", out_valid, 1);
    redirect(32'h83);
    chk("redir_pop_push_empty", out_valid, 0);
    wait_valid("redir_pop_push_wait", 10);
    chk("redir_aligned_pc", out_pc, 32'h80);

    // 5: PC wrap at the top of the address space
    redirect(32'hFFFFFFFF);
    chk("wrap_req", imem_req, 1);
    chk("wrap_addr0", imem_addr, 32'hFFFFFFFC);
    tick();
    chk("wrap_addr1", imem_addr, 32'h0);
    wait_valid("wrap_wait", 10);
    chk("wrap_pc0", out_pc, 32'hFFFFFFFC);
    tick();
    chk("wrap_valid1", out_valid, 1);
    chk("wrap_pc1", out_pc, 32'h0);

    // 6: backward beq at 0x20
    redirect(32'h20);
    wait_valid("beq_wait", 10);
    chk("beq_pc", out_pc, 32'h20);
    chk("beq_instr", out_instr, 32'h1000FFFE);
    tick();
    wait_valid("beq_next_wait", 10);
`ifdef FETCH_STATIC_PREDICT_EN
    chk("beq_next_pc", out_pc, 32'h1C);
`else
    chk("beq_next_pc", out_pc, 32'h24);
`endif
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  // Hard ceiling on simulation time.
  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got running expected done");
    $fatal(1);
  end

endmodule
